// File: rtl/addressing_mode_decoder.sv
// Registered RV32I instruction-format decoder: opcode -> addressing-mode code, field slices, sign-extended immediate.
// Optional build macro ADDRESSING_MODE_SYSTEM_EN enables SYSTEM opcode decode (mode 9) instead of flagging it illegal.
module addressing_mode_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic [3:0]  mode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic        out_valid,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] MODE_ILLEGAL = 4'd0;
    localparam logic [3:0] MODE_R       = 4'd1;
    localparam logic [3:0] MODE_I_ALU   = 4'd2;
    localparam logic [3:0] MODE_LOAD    = 4'd3;
    localparam logic [3:0] MODE_STORE   = 4'd4;
    localparam logic [3:0] MODE_BRANCH  = 4'd5;
    localparam logic [3:0] MODE_JAL     = 4'd6;
    localparam logic [3:0] MODE_LUI     = 4'd7;
    localparam logic [3:0] MODE_AUIPC   = 4'd8;
    localparam logic [3:0] MODE_SYSTEM  = 4'd9;
    localparam logic [3:0] MODE_JALR    = 4'd10;

    function automatic logic [3:0] decode_mode(input logic [6:0] opcode);
        logic [3:0] m;
        case (opcode)
            OP_R:      m = MODE_R;
            OP_I_ALU:  m = MODE_I_ALU;
            OP_LOAD:   m = MODE_LOAD;
            OP_STORE:  m = MODE_STORE;
            OP_BRANCH: m = MODE_BRANCH;
            OP_JAL:    m = MODE_JAL;
            OP_LUI:    m = MODE_LUI;
            OP_AUIPC:  m = MODE_AUIPC;
`ifdef ADDRESSING_MODE_SYSTEM_EN
            OP_SYSTEM: m = MODE_SYSTEM;
`else
            OP_SYSTEM: m = MODE_ILLEGAL;
`endif
            OP_JALR:   m = MODE_JALR;
            default:   m = MODE_ILLEGAL;
        endcase
        return m;
    endfunction

    // Immediate layout is selected by the already-decoded mode so SYSTEM/illegal share the zero path.
    function automatic logic [31:0] build_imm(input logic [31:0] ins, input logic [3:0] m);
        logic [31:0] v;
        case (m)
            MODE_I_ALU, MODE_LOAD, MODE_JALR:
                v = {{20{ins[31]}}, ins[31:20]};
            MODE_STORE:
                v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            MODE_BRANCH:
                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            MODE_JAL:
                v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            MODE_LUI, MODE_AUIPC:
                v = {ins[31:12], 12'h000};
            default:
                v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    logic [3:0]  mode_s;
    logic [31:0] imm_s;
    logic        illegal_s;

    logic [3:0]  mode_q,    mode_d;
    logic [4:0]  rd_q,      rd_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [2:0]  funct3_q,  funct3_d;
    logic [6:0]  funct7_q,  funct7_d;
    logic [31:0] imm_q,     imm_d;
    logic        illegal_q, illegal_d;
    logic        out_valid_q, out_valid_d;

    // Combinational classification of the incoming word.
    always_comb begin
        mode_s    = decode_mode(instr[6:0]);
        imm_s     = build_imm(instr, mode_s);
        illegal_s = (mode_s == MODE_ILLEGAL);
    end

    // Next-state: load a fresh decode on a valid capture, otherwise hold.
    always_comb begin
        mode_d      = mode_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        funct3_d    = funct3_q;
        funct7_d    = funct7_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        out_valid_d = instr_valid;
        if (instr_valid) begin
            mode_d    = mode_s;
            rd_d      = instr[11:7];
            rs1_d     = instr[19:15];
            rs2_d     = instr[24:20];
            funct3_d  = instr[14:12];
            funct7_d  = instr[31:25];
            imm_d     = imm_s;
            illegal_d = illegal_s;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers; asynchronous reset clears everything and drops any capture in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= 4'd0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            funct3_q    <= 3'd0;
            funct7_q    <= 7'd0;
            imm_q       <= 32'h0000_0000;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign mode      = mode_q;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign funct3    = funct3_q;
    assign funct7    = funct7_q;
    assign imm       = imm_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_addressing_mode_decoder.sv
// Self-checking bench for addressing_mode_decoder: directed vectors plus random stream against a reference model.
module tb_addressing_mode_decoder;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  mode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    // Expected output state held by the model
    logic [3:0]  e_mode;
    logic [31:0] e_imm;
    logic [31:0] e_word;
    logic        e_illegal;
    logic        e_valid;

    int mode_tab[int];
    logic [6:0] ops[11];

    addressing_mode_decoder dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .mode(mode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Sign-extend an n-bit field held in the low bits of v
    function automatic logic [31:0] sext(input longint v, input int n);
        longint r;
        r = v & ((64'sd1 <<< n) - 1);
        if (r >= (64'sd1 <<< (n - 1))) r = r - (64'sd1 <<< n);
        return r[31:0];
    endfunction

    function automatic void model_capture(input logic [31:0] w);
        longint u;
        int m;
        u = w;
        m = mode_tab.exists(int'(w[6:0])) ? mode_tab[int'(w[6:0])] : 0;
        e_word    = w;
        e_mode    = m[3:0];
        e_illegal = (m == 0);
        case (m)
            2, 3, 10: e_imm = sext(u >> 20, 12);
            4:        e_imm = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            5:        e_imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                                   (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            6:        e_imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                                   (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            7, 8:     e_imm = w & 32'hFFFF_F000;
            default:  e_imm = 32'h0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".mode"},    {28'd0, mode},    {28'd0, e_mode});
        check_eq({tag, ".rd"},      {27'd0, rd},      {27'd0, e_word[11:7]});
        check_eq({tag, ".rs1"},     {27'd0, rs1},     {27'd0, e_word[19:15]});
        check_eq({tag, ".rs2"},     {27'd0, rs2},     {27'd0, e_word[24:20]});
        check_eq({tag, ".funct3"},  {29'd0, funct3},  {29'd0, e_word[14:12]});
        check_eq({tag, ".funct7"},  {25'd0, funct7},  {25'd0, e_word[31:25]});
        check_eq({tag, ".imm"},     imm,              e_imm);
        check_eq({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e_illegal});
        check_eq({tag, ".valid"},   {31'd0, out_valid}, {31'd0, e_valid});
    endtask

    task automatic model_reset();
        e_word = 32'h0; e_mode = 4'd0; e_imm = 32'h0; e_illegal = 1'b0; e_valid = 1'b0;
    endtask

    // Drive one cycle at negedge, sample 1 time unit after the following posedge
    task automatic step(input logic v, input logic [31:0] w, input string tag);
        @(negedge clk);
        instr_valid = v;
        instr       = w;
        @(posedge clk);
        #1;
        if (v) model_capture(w);
        e_valid = v;
        check_all(tag);
    endtask

    initial begin
        mode_tab[7'b0110011] = 1;  mode_tab[7'b0010011] = 2;
        mode_tab[7'b0000011] = 3;  mode_tab[7'b0100011] = 4;
        mode_tab[7'b1100011] = 5;  mode_tab[7'b1101111] = 6;
        mode_tab[7'b0110111] = 7;  mode_tab[7'b0010111] = 8;
        mode_tab[7'b1100111] = 10;
`ifdef ADDRESSING_MODE_SYSTEM_EN
        mode_tab[7'b1110011] = 9;
`endif
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                7'b0110111, 7'b0010111, 7'b1110011, 7'b1100111, 7'b1111111};

        rst = 1'b0; instr_valid = 1'b0; instr = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        step(1'b1, 32'h0050_0093, "addi");
        check_eq("addi.imm_const", imm, 32'h0000_0005);
        check_eq("addi.mode_const", {28'd0, mode}, 32'd2);
        step(1'b0, 32'h0050_0093, "addi_hold");
        step(1'b1, 32'h0020_81B3, "add");
        check_eq("add.rs2_const", {27'd0, rs2}, 32'd2);
        step(1'b1, 32'h0020_A423, "sw");
        check_eq("sw.imm_const", imm, 32'h0000_0008);
        step(1'b1, 32'hFE00_0EE3, "beq");
        check_eq("beq.imm_const", imm, 32'hFFFF_FFFC);
        step(1'b1, 32'h0100_00EF, "jal");
        check_eq("jal.imm_const", imm, 32'h0000_0010);
        step(1'b1, 32'h1234_52B7, "lui");
        check_eq("lui.imm_const", imm, 32'h1234_5000);
        step(1'b1, 32'h0000_007F, "illegal");
        check_eq("illegal.flag_const", {31'd0, illegal}, 32'd1);
        step(1'b1, 32'h0000_0073, "system");
`ifdef ADDRESSING_MODE_SYSTEM_EN
        check_eq("system.mode_const", {28'd0, mode}, 32'd9);
`else
        check_eq("system.illegal_const", {31'd0, illegal}, 32'd1);
`endif
        step(1'b0, 32'hFFFF_FFFF, "idle");

        // Random stream: mostly legal opcodes, occasional junk and idle cycles
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
            step(($urandom_range(0, 3) != 0), w, "rand");
        end

        // Reset asserted mid-cycle after a valid capture clears outputs immediately
        step(1'b1, 32'hFE00_0EE3, "pre_rst");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        step(1'b0, 32'h0050_0093, "post_rst_idle");
        step(1'b0, 32'h0050_0093, "post_rst_idle2");

        // Capture in flight when reset hits is dropped
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 32'h1234_52B7;
        #2;
        rst = 1'b0;
        #1;
        check_all("inflight_rst");
        @(posedge clk);
        #1;
        check_all("inflight_rst_edge");
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        step(1'b0, 32'h0, "inflight_release");
        step(1'b1, 32'h0020_A423, "first_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
